dmac_bus_arbiter: RTL

- Two-master AHB-lite arbiter and master multiplexer directly upstream of the DMAC's bus-grant input.
- Master 0 is the CPU and is the default master; master 1 is the DMAC (Bus_Req/Bus_Grant, MAddress/MTrans/MWrite/MWData/MBurst_Size).
- Decides ownership, holds the DMAC grant for whole bursts, and drives the shared address/control and data buses to the slave fabric with correct AHB address-phase/data-phase ownership skew.

---
 rtl/dmac_pkg.sv | 29 ++
 rtl/dmac_burst_tracker.sv | 52 +++++
 rtl/dmac_bus_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/dmac_pkg.sv
// Shared types and helpers for the DMAC bus arbiter slice.
package dmac_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic {
    CPU_OWN = 1'b0,
    DMA_OWN = 1'b1
  } arb_state_e;

  localparam logic MST_CPU = 1'b0;
  localparam logic MST_DMA = 1'b1;

  // NONSEQ/SEQ transfer data; IDLE/BUSY do not
  function automatic logic is_active(input logic [1:0] trans);
    return (trans == NONSEQ) || (trans == SEQ);
  endfunction

  // A programmed burst length of zero still moves one beat
  function automatic logic [3:0] eff_len(input logic [3:0] len);
    return (len == 4'd0) ? 4'd1 : len;
  endfunction

endpackage

// File: rtl/dmac_burst_tracker.sv
// Beat and burst bookkeeping for DMAC ownership periods.
module dmac_burst_tracker
  import dmac_pkg::*;
#(
  parameter int MAX_BURSTS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       beat,
  input  logic       release_bus,
  input  logic [3:0] burst_len,
  output logic       burst_end,
  output logic       max_reached
);

  logic [3:0] beat_cnt;
  logic [3:0] len_q;
  logic [2:0] burst_cnt;
  logic [2:0] burst_cnt_inc;

  assign burst_end     = beat && ((beat_cnt + 4'd1) == len_q);
  // >= rather than == so a cpu_req raised after many bursts still forces a handover
  assign max_reached   = ({1'b0, burst_cnt} + 4'd1) >= 4'(MAX_BURSTS);
  assign burst_cnt_inc = (burst_cnt == 3'd7) ? burst_cnt : burst_cnt + 3'd1;

  // Counters advance only on accepted beats, so HReady low freezes them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt  <= 4'd0;
      burst_cnt <= 3'd0;
      len_q     <= 4'd1;
    end else if (start) begin
      beat_cnt  <= 4'd0;
      burst_cnt <= 3'd0;
      len_q     <= eff_len(burst_len);
    end else if (burst_end) begin
      beat_cnt <= 4'd0;
      if (release_bus) begin
        burst_cnt <= 3'd0;
      end else begin
        burst_cnt <= burst_cnt_inc;
        len_q     <= eff_len(burst_len);
      end
    end else if (beat) begin
      beat_cnt <= beat_cnt + 4'd1;
    end else if (release_bus) begin
      burst_cnt <= 3'd0;
    end
  end

endmodule

// File: rtl/dmac_bus_arbiter.sv
// Two-master AHB-lite arbiter and bus mux: CPU (default) and DMAC.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   CPU_OWN | CPU owns the address phase (default master)
//   DMA_OWN | DMAC granted; held until burst end or release
module dmac_bus_arbiter
  import dmac_pkg::*;
#(
  parameter bit DMA_HIGH_PRIO  = 1'b1,
  parameter int DMA_MAX_BURSTS = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_haddr,
  input  logic [1:0]        cpu_htrans,
  input  logic              cpu_hwrite,
  input  logic [DATA_W-1:0] cpu_hwdata,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_haddr,
  input  logic [1:0]        dma_htrans,
  input  logic              dma_hwrite,
  input  logic [DATA_W-1:0] dma_hwdata,
  input  logic [3:0]        dma_burst_len,
  input  logic              HReady,
  output logic              cpu_grant,
  output logic              dma_grant,
  output logic [ADDR_W-1:0] HAddr,
  output logic [1:0]        HTrans,
  output logic              HWrite,
  output logic [DATA_W-1:0] HWData,
  output logic              addr_owner,
  output logic              data_owner
);

  arb_state_e state_q, state_d;
  logic switch_pt, cpu_blocks, dma_beat, early_rel;
  logic start, release_bus, burst_end, max_reached;
  logic addr_sel;

  assign switch_pt   = HReady && ((cpu_htrans == IDLE) || !cpu_req);
  assign cpu_blocks  = !DMA_HIGH_PRIO && cpu_req;
  assign dma_beat    = (state_q == DMA_OWN) && HReady && is_active(dma_htrans);
  assign early_rel   = HReady && !dma_req && (dma_htrans == IDLE);
  assign start       = (state_q == CPU_OWN) && (state_d == DMA_OWN);
  assign release_bus = (state_q == DMA_OWN) && (state_d == CPU_OWN);

  dmac_burst_tracker #(
    .MAX_BURSTS(DMA_MAX_BURSTS)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .beat       (dma_beat),
    .release_bus(release_bus),
    .burst_len  (dma_burst_len),
    .burst_end  (burst_end),
    .max_reached(max_reached)
  );

  // Ownership state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= CPU_OWN;
    else      state_q <= state_d;
  end

  // Next-state: grant at CPU switch points, hold DMAC for whole bursts
  always_comb begin
    state_d = state_q;
    case (state_q)
      CPU_OWN: begin
        if (switch_pt && dma_req && !cpu_blocks) state_d = DMA_OWN;
      end
      DMA_OWN: begin
        if (burst_end) begin
          if ((cpu_req && (max_reached || !DMA_HIGH_PRIO)) || !dma_req) state_d = CPU_OWN;
        end else if (early_rel) begin
          state_d = CPU_OWN;
        end
      end
      default: state_d = CPU_OWN;
    endcase
  end

  // Data phase lags the address phase by one accepted transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        data_owner <= MST_CPU;
    else if (HReady) data_owner <= addr_owner;
  end

  // Grants and master multiplexing
  always_comb begin
    addr_sel   = (state_q == DMA_OWN) ? MST_DMA : MST_CPU;
    addr_owner = addr_sel;
    cpu_grant  = (addr_sel == MST_CPU);
    dma_grant  = (addr_sel == MST_DMA);
    if (addr_sel == MST_DMA) begin
      HAddr  = dma_haddr;
      HTrans = dma_htrans;
      HWrite = dma_hwrite;
    end else begin
      HAddr  = cpu_haddr;
      HTrans = cpu_htrans;
      HWrite = cpu_hwrite;
    end
    HWData = (data_owner == MST_DMA) ? dma_hwdata : cpu_hwdata;
  end

endmodule
